spike_writeback_ctrl: RTL

Clocked write-back stage on the memory side of the NoC. Accepts 35-bit membrane and spike result packets from the adder's packetizer, as delivered by the NoC to the memory port. Buffers them in a small FIFO and issues one write per packet to the memory array over a valid/ready port. Tracks completion of each timestep's output map and pulses a done indication so the upstream scheduler can start the next timestep.

---
 rtl/snn_pkg.sv | 40 ++++
 rtl/swb_fifo.sv | 52 +++++
 rtl/spike_writeback_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN NoC: packet layout, packet type codes,
// node addresses and the decoded packet struct.
package snn_pkg;

    localparam int PKT_W    = 35;
    localparam int SRC_LSB  = 32;
    localparam int DST_LSB  = 29;
    localparam int TYPE_LSB = 27;
    localparam int X_LSB    = 24;
    localparam int Y_LSB    = 21;
    localparam int T_BIT    = 20;
    localparam int DATA_LSB = 0;

    localparam logic [1:0] PKT_IFMAP  = 2'b00;
    localparam logic [1:0] PKT_FILTER = 2'b01;
    localparam logic [1:0] PKT_MEMB   = 2'b10;
    localparam logic [1:0] PKT_SPIKE  = 2'b11;

    localparam logic [2:0] ADDR_MEM   = 3'b000;
    localparam logic [2:0] ADDR_PE0   = 3'b001;
    localparam logic [2:0] ADDR_PE1   = 3'b010;
    localparam logic [2:0] ADDR_PE2   = 3'b011;
    localparam logic [2:0] ADDR_ADDER = 3'b100;

    typedef struct packed {
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [1:0]  typ;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        t;
        logic [19:0] data;
    } pkt_t;

    // Only membrane and spike results are meaningful at the memory node.
    function automatic logic is_result(input logic [1:0] typ);
        return (typ == PKT_MEMB) || (typ == PKT_SPIKE);
    endfunction

endpackage

// File: rtl/swb_fifo.sv
// Packet FIFO for the write-back stage. A written entry becomes visible to
// the read side one cycle after the write, which gives the two-edge
// accept-to-request latency of the write-back path.
module swb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      wr_ptr_vis;
    logic [AW:0]      rd_ptr;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr_vis == rd_ptr);
    assign rdata = store[rd_ptr[AW-1:0]];

    // Storage array, no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            store[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; wr_ptr_vis trails wr_ptr by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            wr_ptr_vis <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            wr_ptr_vis <= wr_ptr;
        end
    end

endmodule

// File: rtl/spike_writeback_ctrl.sv
// Memory-side write-back controller: filters NoC result packets, queues them,
// issues one memory write per packet and signals timestep completion.
// Optional feature macro: SWB_SPIKE_CNT_EN adds the spike_cnt output.
//
// state  | meaning
// IDLE   | no request outstanding, waiting for an eligible FIFO head
// SEND   | mem_valid high, outputs held until mem_ready
module spike_writeback_ctrl
    import snn_pkg::*;
#(
    parameter logic [2:0] THIS_ADDR = ADDR_MEM,
    parameter int         DEPTH     = 4,
    parameter int         OUT_DIM   = 3,
    parameter int         DATA_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [34:0]       pkt_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_sel,
    output logic              mem_t,
    output logic [2:0]        mem_x,
    output logic [2:0]        mem_y,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ts_done,
    output logic              ts_done_t,
    output logic [7:0]        drop_cnt,
    output logic              dup_err
`ifdef SWB_SPIKE_CNT_EN
    ,
    output logic [3:0]        spike_cnt
`endif
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;
    localparam int         NB     = OUT_DIM * OUT_DIM;
    localparam logic [2:0] DIM3   = 3'(OUT_DIM);

    pkt_t             in_pkt;
    pkt_t             head;
    logic [PKT_W-1:0] head_raw;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pkt_ok;
    logic             push;
    logic             drop;
    logic             head_ok;
    logic             load;
    logic             mem_hs;
    logic             ts_complete;
    logic             dup_hit;
    logic [0:0]       state;
    logic             cur_t;
    logic [5:0]       hs_idx;
    logic [NB-1:0]    hs_mask;
    logic [NB-1:0]    memb_map;
    logic [NB-1:0]    spk_map;
    logic [NB-1:0]    memb_next;
    logic [NB-1:0]    spk_next;
    logic             unused_fields;

    assign in_pkt    = pkt_t'(pkt_data);
    assign pkt_ok    = (in_pkt.dst == THIS_ADDR) && is_result(in_pkt.typ)
                       && (in_pkt.x < DIM3) && (in_pkt.y < DIM3);
    assign pkt_ready = !fifo_full;
    assign push      = pkt_valid && pkt_ready && pkt_ok;
    assign drop      = pkt_valid && pkt_ready && !pkt_ok;

    swb_fifo #(.DEPTH(DEPTH), .WIDTH(PKT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (pkt_data),
        .pop   (load),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head      = pkt_t'(head_raw);
    assign head_ok   = !fifo_empty && (head.t == cur_t);
    assign mem_valid = (state == S_SEND);
    assign mem_hs    = mem_valid && mem_ready;
    assign load      = head_ok && ((state == S_IDLE) || mem_hs);

    assign hs_idx      = 6'(mem_y) * 6'(DIM3) + 6'(mem_x);
    assign hs_mask     = mem_hs ? (NB'(1) << hs_idx) : '0;
    assign memb_next   = memb_map | (mem_sel ? '0 : hs_mask);
    assign spk_next    = spk_map  | (mem_sel ? hs_mask : '0);
    assign dup_hit     = |(hs_mask & (mem_sel ? spk_map : memb_map));
    assign ts_complete = mem_hs && (&memb_next) && (&spk_next);

    assign unused_fields = ^{in_pkt.src, in_pkt.t, in_pkt.data, head.src, head.dst};

    // Request FSM and output registers, reloaded straight from the head for back-to-back writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_sel   <= 1'b0;
            mem_t     <= 1'b0;
            mem_x     <= '0;
            mem_y     <= '0;
            mem_wdata <= '0;
        end else begin
            if (load) begin
                mem_sel   <= (head.typ == PKT_SPIKE);
                mem_t     <= head.t;
                mem_x     <= head.x;
                mem_y     <= head.y;
                mem_wdata <= (head.typ == PKT_SPIKE) ? DATA_W'(head.data[0]) : DATA_W'(head.data);
            end
            if (state == S_IDLE) begin
                if (load) state <= S_SEND;
            end else if (mem_hs && !load) begin
                state <= S_IDLE;
            end
        end
    end

    // Completion tracking: bitmaps per array, duplicate flag and timestep toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memb_map  <= '0;
            spk_map   <= '0;
            cur_t     <= 1'b0;
            ts_done   <= 1'b0;
            ts_done_t <= 1'b0;
            dup_err   <= 1'b0;
        end else begin
            ts_done <= ts_complete;
            if (dup_hit) dup_err <= 1'b1;
            if (ts_complete) begin
                ts_done_t <= cur_t;
                cur_t     <= ~cur_t;
                memb_map  <= '0;
                spk_map   <= '0;
            end else begin
                memb_map  <= memb_next;
                spk_map   <= spk_next;
            end
        end
    end

    // Saturating count of packets rejected at the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef SWB_SPIKE_CNT_EN
    logic [3:0] spike_run;
    logic       spike_hit;

    assign spike_hit = mem_hs && mem_sel && mem_wdata[0];

    // Running spike count, latched and cleared when the timestep completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_run <= '0;
            spike_cnt <= '0;
        end else if (ts_complete) begin
            spike_cnt <= spike_run + 4'(spike_hit);
            spike_run <= '0;
        end else begin
            spike_run <= spike_run + 4'(spike_hit);
        end
    end
`endif

endmodule
